// File: rtl/gpio_stream_packer.sv
// gpio_stream_packer
//   Captures 128-bit vector stores strobed by GPIOEnR/GPIOEnG/GPIOEnB, plus the
//   end-of-image edge on GPIOEn, into a FIFO. Each entry is sent as a framed
//   byte sequence (header, B0..B3) over a valid/ready byte link.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     GPIO[127:0]              vector store data (one byte taken from each lane)
//     GPIOEnR/GPIOEnG/GPIOEnB  plane store strobes (priority R > G > B)
//     GPIOEn                   end-of-image level; its rising edge queues an END entry
//     tx_data/tx_valid/tx_ready  byte link
//     overflow                 sticky, an entry was dropped on a full FIFO
//     strb_err                 sticky, several plane strobes in one cycle
//     busy                     FIFO not empty or a frame is in progress
//
//   Build option: define GPIO_STREAM_CKSUM_EN to append an XOR checksum byte
//   (header ^ B0 ^ B1 ^ B2 ^ B3) to every frame.

module gpio_stream_packer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  HDR_R      = 8'hA1,
    parameter logic [7:0]  HDR_G      = 8'hA2,
    parameter logic [7:0]  HDR_B      = 8'hA3,
    parameter logic [7:0]  HDR_END    = 8'hE0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] GPIO,
    input  logic         GPIOEnR,
    input  logic         GPIOEnG,
    input  logic         GPIOEnB,
    input  logic         GPIOEn,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         overflow,
    output logic         strb_err,
    output logic         busy
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

    localparam logic [1:0] TAG_END = 2'b00;
    localparam logic [1:0] TAG_R   = 2'b01;
    localparam logic [1:0] TAG_G   = 2'b10;
    localparam logic [1:0] TAG_B   = 2'b11;

`ifdef GPIO_STREAM_CKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_D0, S_D1, S_D2, S_D3, S_CK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_D0, S_D1, S_D2, S_D3} state_t;
`endif

    state_t state, state_n;

    // ---------------- capture ----------------
    logic        en_q;
    logic        pend_end;
    logic        strb_any;
    logic        strb_multi;
    logic        end_req;
    logic [1:0]  strb_tag;
    logic        push_req;
    logic [33:0] push_data;

    // Only the low byte of each lane is forwarded to the link.
    logic unused_gpio_bits;
    assign unused_gpio_bits = ^{GPIO[127:104], GPIO[95:72], GPIO[63:40], GPIO[31:8]};

    always_comb begin
        strb_any   = GPIOEnR | GPIOEnG | GPIOEnB;
        strb_multi = (GPIOEnR & GPIOEnG) | (GPIOEnR & GPIOEnB) | (GPIOEnG & GPIOEnB);
        strb_tag   = GPIOEnR ? TAG_R : (GPIOEnG ? TAG_G : TAG_B);
        end_req    = (GPIOEn & ~en_q) | pend_end;
        push_req   = strb_any | end_req;
        // END entries carry zero data so the checksum of an END frame is HDR_END.
        push_data  = strb_any ? {strb_tag, GPIO[103:96], GPIO[71:64], GPIO[39:32], GPIO[7:0]}
                              : {TAG_END, 32'h0};
    end

    // ---------------- FIFO ----------------
    logic [33:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          empty, full, pop, push_ok;
    logic [33:0]   frame;

    always_comb begin
        empty   = (count == '0);
        full    = (count == FULL_CNT);
        pop     = (state == S_IDLE) && !empty;
        // A full FIFO still accepts a push when the same cycle pops.
        push_ok = push_req && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q     <= 1'b0;
            pend_end <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            strb_err <= 1'b0;
            frame    <= '0;
        end else begin
            en_q <= GPIOEn;
            // A strobe wins the push slot; a coinciding END waits one cycle.
            pend_end <= strb_any & end_req;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                frame  <= mem[rd_ptr];
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push_req && full && !pop) overflow <= 1'b1;
            if (strb_multi) strb_err <= 1'b1;
        end
    end

    // ---------------- framing FSM ----------------
    logic [7:0] hdr_byte;

    always_comb begin
        case (frame[33:32])
            TAG_R:   hdr_byte = HDR_R;
            TAG_G:   hdr_byte = HDR_G;
            TAG_B:   hdr_byte = HDR_B;
            default: hdr_byte = HDR_END;
        endcase
    end

`ifdef GPIO_STREAM_CKSUM_EN
    logic [7:0] cksum;
    assign cksum = hdr_byte ^ frame[31:24] ^ frame[23:16] ^ frame[15:8] ^ frame[7:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        tx_valid = 1'b0;
        tx_data  = '0;
        case (state)
            S_IDLE: if (!empty) state_n = S_HDR;
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_byte;
                if (tx_ready) begin
`ifdef GPIO_STREAM_CKSUM_EN
                    state_n = (frame[33:32] == TAG_END) ? S_CK : S_D0;
`else
                    state_n = (frame[33:32] == TAG_END) ? S_IDLE : S_D0;
`endif
                end
            end
            S_D0: begin
                tx_valid = 1'b1;
                tx_data  = frame[31:24];
                if (tx_ready) state_n = S_D1;
            end
            S_D1: begin
                tx_valid = 1'b1;
                tx_data  = frame[23:16];
                if (tx_ready) state_n = S_D2;
            end
            S_D2: begin
                tx_valid = 1'b1;
                tx_data  = frame[15:8];
                if (tx_ready) state_n = S_D3;
            end
            S_D3: begin
                tx_valid = 1'b1;
                tx_data  = frame[7:0];
`ifdef GPIO_STREAM_CKSUM_EN
                if (tx_ready) state_n = S_CK;
`else
                if (tx_ready) state_n = S_IDLE;
`endif
            end
`ifdef GPIO_STREAM_CKSUM_EN
            S_CK: begin
                tx_valid = 1'b1;
                tx_data  = cksum;
                if (tx_ready) state_n = S_IDLE;
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    assign busy = !empty || (state != S_IDLE);

endmodule

// File: tb/tb_gpio_stream_packer.sv
// Directed bench for gpio_stream_packer: one task per scenario, inline checks.
module tb_gpio_stream_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] GPIO = '0;
    logic         GPIOEnR = 1'b0, GPIOEnG = 1'b0, GPIOEnB = 1'b0, GPIOEn = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic         overflow, strb_err, busy;

    int tests = 0;
    int fails = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    gpio_stream_packer #(.FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .GPIO(GPIO),
        .GPIOEnR(GPIOEnR), .GPIOEnG(GPIOEnG), .GPIOEnB(GPIOEnB), .GPIOEn(GPIOEn),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .overflow(overflow), .strb_err(strb_err), .busy(busy)
    );

    // Inputs change 1 time unit after the rising edge, so the falling edge
    // sees the values that the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) got_q.push_back(tx_data);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk_gpio(input logic [7:0] b0, b1, b2, b3);
        return {24'h5A5A5A, b0, 24'hC3C3C3, b1, 24'h969696, b2, 24'h3C3C3C, b3};
    endfunction

    task automatic strobe(input logic r, g, b, input logic [7:0] b0, b1, b2, b3);
        GPIO = mk_gpio(b0, b1, b2, b3);
        GPIOEnR = r; GPIOEnG = g; GPIOEnB = b;
        cycle();
        GPIOEnR = 1'b0; GPIOEnG = 1'b0; GPIOEnB = 1'b0;
    endtask

    task automatic exp_frame(input logic [7:0] hdr, b0, b1, b2, b3);
        exp_q.push_back(hdr); exp_q.push_back(b0); exp_q.push_back(b1);
        exp_q.push_back(b2);  exp_q.push_back(b3);
`ifdef GPIO_STREAM_CKSUM_EN
        exp_q.push_back(hdr ^ b0 ^ b1 ^ b2 ^ b3);
`endif
    endtask

    task automatic exp_end();
        exp_q.push_back(8'hE0);
`ifdef GPIO_STREAM_CKSUM_EN
        exp_q.push_back(8'hE0);
`endif
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int k = 0; k < budget && got_q.size() < n; k++) cycle();
        repeat (4) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        GPIOEnR = 1'b0; GPIOEnG = 1'b0; GPIOEnB = 1'b0; GPIOEn = 1'b0; tx_ready = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        tests += 5;
        if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
        if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", tx_data); end
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        if (strb_err !== 1'b0) begin fails++; $display("FAIL reset_serr: got %b want 0", strb_err); end
    endtask

    task automatic test_single();
        got_q.delete(); exp_q.delete();
        tx_ready = 1'b1;
        GPIO = 128'h000000AA_000000BB_000000CC_000000DD;
        GPIOEnR = 1'b1;
        cycle();                      // now cycle N+1
        GPIOEnR = 1'b0;
        tests++;
        if (tx_valid !== 1'b0) begin fails++; $display("FAIL single_n1_valid: got %b want 0", tx_valid); end
        cycle();                      // now cycle N+2
        tests += 2;
        if (tx_valid !== 1'b1) begin fails++; $display("FAIL single_n2_valid: got %b want 1", tx_valid); end
        if (tx_data !== 8'hA1) begin fails++; $display("FAIL single_n2_hdr: got %h want a1", tx_data); end
        exp_frame(8'hA1, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
        wait_bytes(exp_q.size(), 50);
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL single_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL single_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL single_busy: got %b want 0", busy); end
    endtask

    task automatic test_stall();
        got_q.delete(); exp_q.delete();
        tx_ready = 1'b0;
        strobe(1, 0, 0, 8'h11, 8'h12, 8'h13, 8'h14);
        strobe(0, 1, 0, 8'h21, 8'h22, 8'h23, 8'h24);
        strobe(0, 0, 1, 8'h31, 8'h32, 8'h33, 8'h34);
        for (int i = 0; i < 20; i++) begin
            tests++;
            if (tx_valid !== 1'b1 || tx_data !== 8'hA1) begin
                fails++; $display("FAIL stall_hold%0d: got valid=%b data=%h want 1/a1", i, tx_valid, tx_data);
            end
            cycle();
        end
        tx_ready = 1'b1;
        exp_frame(8'hA1, 8'h11, 8'h12, 8'h13, 8'h14);
        exp_frame(8'hA2, 8'h21, 8'h22, 8'h23, 8'h24);
        exp_frame(8'hA3, 8'h31, 8'h32, 8'h33, 8'h34);
        wait_bytes(exp_q.size(), 100);
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL stall_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL stall_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    // The first entry is popped into the frame register while tx_ready is low,
    // so the FIFO fills on the 17th strobe and the 18th is the one dropped.
    task automatic test_overflow();
        got_q.delete(); exp_q.delete();
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            strobe(1, 0, 0, 8'(i), 8'(i + 8'h40), 8'(i + 8'h80), 8'(i + 8'hC0));
            exp_frame(8'hA1, 8'(i), 8'(i + 8'h40), 8'(i + 8'h80), 8'(i + 8'hC0));
        end
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_at_full: got %b want 0", overflow); end
        strobe(1, 0, 0, 8'hEE, 8'hEE, 8'hEE, 8'hEE);
        tests++;
        if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b want 1", overflow); end
        tx_ready = 1'b1;
        wait_bytes(exp_q.size(), 300);
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL ovf_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL ovf_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        tests++;
        if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_reset_midframe();
        got_q.delete(); exp_q.delete();
        tx_ready = 1'b0;
        strobe(0, 1, 0, 8'h01, 8'h02, 8'h03, 8'h04);
        cycle(); cycle();
        tests++;
        if (tx_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_valid: got %b want 1", tx_valid); end
        rst = 1'b1;
        #1;
        tests += 3;
        if (tx_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b want 0", tx_valid); end
        if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b want 0", busy); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL mid_ovf: got %b want 0", overflow); end
        cycle();
        rst = 1'b0;
        got_q.delete();
        tx_ready = 1'b1;
        repeat (10) cycle();
        tests += 2;
        if (got_q.size() != 0) begin fails++; $display("FAIL mid_nobytes: got %0d want 0", got_q.size()); end
        if (busy !== 1'b0) begin fails++; $display("FAIL mid_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_overflow_pop();
        bit found;
        got_q.delete(); exp_q.delete();
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            strobe(0, 1, 0, 8'(i + 8'h10), 8'(i + 8'h20), 8'(i + 8'h30), 8'(i + 8'h50));
            exp_frame(8'hA2, 8'(i + 8'h10), 8'(i + 8'h20), 8'(i + 8'h30), 8'(i + 8'h50));
        end
        tx_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            if (tx_valid === 1'b0) found = 1'b1;
        end
        tests++;
        if (!found) begin fails++; $display("FAIL ovfpop_idle: got no idle cycle want one within 20"); end
        // FSM is in IDLE with a full FIFO: this push coincides with the pop.
        strobe(0, 0, 1, 8'h71, 8'h72, 8'h73, 8'h74);
        exp_frame(8'hA3, 8'h71, 8'h72, 8'h73, 8'h74);
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL ovfpop_flag: got %b want 0", overflow); end
        wait_bytes(exp_q.size(), 300);
        tests += 2;
        if (overflow !== 1'b0) begin fails++; $display("FAIL ovfpop_flag_end: got %b want 0", overflow); end
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL ovfpop_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL ovfpop_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_strb_err();
        got_q.delete(); exp_q.delete();
        tx_ready = 1'b1;
        tests++;
        if (strb_err !== 1'b0) begin fails++; $display("FAIL serr_pre: got %b want 0", strb_err); end
        strobe(1, 1, 0, 8'h55, 8'h66, 8'h77, 8'h88);
        tests++;
        if (strb_err !== 1'b1) begin fails++; $display("FAIL serr_set: got %b want 1", strb_err); end
        exp_frame(8'hA1, 8'h55, 8'h66, 8'h77, 8'h88);
        wait_bytes(exp_q.size(), 50);
        repeat (5) cycle();
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL serr_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL serr_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_end_marker();
        got_q.delete(); exp_q.delete();
        tx_ready = 1'b1;
        GPIOEn = 1'b1;
        strobe(0, 0, 1, 8'h99, 8'h9A, 8'h9B, 8'h9C);
        repeat (10) cycle();
        exp_frame(8'hA3, 8'h99, 8'h9A, 8'h9B, 8'h9C);
        exp_end();
        wait_bytes(exp_q.size(), 50);
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL end_len1: got %0d want %0d", got_q.size(), exp_q.size()); end
        GPIOEn = 1'b0;
        cycle();
        GPIOEn = 1'b1;
        repeat (10) cycle();
        GPIOEn = 1'b0;
        exp_end();
        wait_bytes(exp_q.size(), 50);
        tests++;
        if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL end_len2: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL end_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL end_busy: got %b want 0", busy); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_overflow();
        test_reset_midframe();
        test_overflow_pop();
        test_strb_err();
        test_end_marker();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
